fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 130 +++++++++++++
 tb/tb_fetch_stage.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
`timescale 1ns/1ps
// Instruction fetch stage: a single-outstanding-request fetch FSM feeding a
// 2-entry instruction queue toward decode, with redirect flush of both.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_cur,
    output logic [31:0] pc_next,
    output logic        pc_hold,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    input  logic        id_ready
);
    // state | meaning
    // IDLE  | nothing outstanding; issue next fetch when a queue slot is free
    // REQ   | request presented to imem, waiting for grant
    // WAIT  | request granted, read data will be pushed into the queue
    // DROP  | granted request made stale by redirect; its data is discarded
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    localparam logic [1:0] QFULL = 2'(QDEPTH);

    state_t      state;
    logic [1:0]  count;
    logic [31:0] inflight_pc;
    logic        rd_ptr;
    logic        wr_ptr;
    logic [31:0] q_pc    [2];
    logic [31:0] q_instr [2];

    logic slot_free;
    logic granted;
    logic push;
    logic pop;

    assign slot_free = (count < QFULL);
    assign granted   = !rst && (state == REQ) && imem_gnt;
    assign push      = (state == WAIT) && imem_rvalid && !redirect;
    assign pop       = id_valid && id_ready && !redirect;

    assign imem_req  = !rst && (state == REQ) && !redirect;
    assign imem_addr = {pc_cur[31:2], 2'b00};

    assign id_valid  = (count != 2'd0);
    assign id_instr  = q_instr[rd_ptr];
    assign id_pc     = q_pc[rd_ptr];

    always_comb begin
        pc_next = pc_cur;
        pc_hold = 1'b1;
        if (rst) begin
            pc_next = RESET_PC;
        end else if (redirect) begin
            pc_next = redirect_pc;
            pc_hold = 1'b0;
        end else if (granted) begin
            pc_next = pc_cur + 32'd4;
            pc_hold = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            count       <= 2'd0;
            inflight_pc <= 32'h0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (slot_free && !redirect)
                        state <= REQ;
                end
                REQ: begin
                    if (imem_gnt) begin
                        inflight_pc <= imem_addr;
                        state       <= redirect ? DROP : WAIT;
                    end else if (redirect) begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (imem_rvalid)
                        state <= IDLE;
                    else if (redirect)
                        state <= DROP;
                end
                DROP: begin
                    // Returning data always closes the stale transaction, even
                    // under a fresh redirect, so the FSM can never wait forever.
                    if (imem_rvalid)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (redirect) begin
                count  <= 2'd0;
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
            end else begin
                if (push)
                    wr_ptr <= ~wr_ptr;
                if (pop)
                    rd_ptr <= ~rd_ptr;
                count <= count + {1'b0, push} - {1'b0, pop};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            q_pc[wr_ptr]    <= inflight_pc;
            q_instr[wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
// Bench for fetch_stage: a latency-randomised instruction memory, a PC register,
// and an in-order fetch model whose expected {pc,instr} stream feeds a scoreboard.
module tb_fetch_stage;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_cur;
    logic [31:0] pc_next;
    logic        pc_hold;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_ready;

    fetch_stage #(.RESET_PC(RESET_PC), .QDEPTH(2)) dut (
        .clk(clk), .rst(rst), .pc_cur(pc_cur), .pc_next(pc_next), .pc_hold(pc_hold),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_ready(id_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst)
            pc_cur <= RESET_PC;
        else if (!pc_hold)
            pc_cur <= pc_next;
    end

    typedef enum int {M_NONE, M_LIVE, M_STALE} mstate_t;

    int          checks = 0;
    int          failures = 0;
    int          n_grants = 0;
    int          n_pushes = 0;
    int          n_pops = 0;
    logic [31:0] glog [$];
    logic [63:0] exp_q [$];

    mstate_t     mo = M_NONE;
    int          lat_left = 0;
    logic [31:0] o_addr;
    logic [31:0] o_data;
    logic [31:0] m_fetch_pc = RESET_PC;
    logic [31:0] last_gnt_pc_next = 32'h0;

    int          gnt_pct = 100;
    int          ready_pct = 100;
    int          lat_min = 1;
    int          lat_max = 1;
    int          redir_pm = 0;
    bit          force_redir = 1'b0;
    logic [31:0] force_pc = 32'h0;
    bit          stale_rv = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive memory/decode/redirect, check PC control, update model.
    task automatic cycle();
        logic        req_phase, do_gnt, do_rv, do_red, accepted;
        logic [31:0] rpc;
        @(negedge clk);
        do_rv       = !rst && (mo != M_NONE) && (lat_left == 0);
        do_gnt      = !rst && ($urandom_range(99) < gnt_pct);
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_gnt    = do_gnt;
        imem_rvalid = do_rv || (stale_rv && !rst);
        imem_rdata  = do_rv ? o_data : $urandom();
        id_ready    = ($urandom_range(99) < ready_pct);
        #1;
        req_phase = imem_req;
        if (req_phase) begin
            chk("single_outstanding", 32'(mo == M_NONE), 32'd1);
            chk("imem_addr", imem_addr, m_fetch_pc);
        end
        do_red = !rst && (force_redir || ($urandom_range(999) < redir_pm));
        if (do_rv && mo == M_STALE && !force_redir)
            do_red = 1'b0;
        rpc = force_redir ? force_pc : ($urandom() & 32'hFFFF_FFFC);
        if (do_red) begin
            redirect    = 1'b1;
            redirect_pc = rpc;
        end
        #1;
        accepted = req_phase && do_gnt;
        if (rst) begin
            chk("rst_pc_hold", pc_hold, 32'd1);
            chk("rst_pc_next", pc_next, RESET_PC);
        end else if (do_red) begin
            chk("redir_pc_next", pc_next, rpc);
            chk("redir_pc_hold", pc_hold, 32'd0);
            chk("redir_req_withdrawn", imem_req, 32'd0);
        end else if (accepted) begin
            chk("gnt_pc_next", pc_next, m_fetch_pc + 32'd4);
            chk("gnt_pc_hold", pc_hold, 32'd0);
            last_gnt_pc_next = pc_next;
        end else begin
            chk("idle_pc_hold", pc_hold, 32'd1);
            chk("idle_pc_next", pc_next, pc_cur);
        end
        #1;
        if (rst) begin
            exp_q.delete();
            mo         = M_NONE;
            m_fetch_pc = RESET_PC;
        end else begin
            if (do_rv) begin
                if (mo == M_LIVE && !do_red) begin
                    exp_q.push_back({o_addr, o_data});
                    n_pushes++;
                end
                mo = M_NONE;
            end else if (mo != M_NONE) begin
                lat_left--;
            end
            if (do_red) begin
                exp_q.delete();
                if (mo == M_LIVE)
                    mo = M_STALE;
            end
            if (accepted) begin
                mo       = do_red ? M_STALE : M_LIVE;
                o_addr   = m_fetch_pc;
                o_data   = $urandom();
                lat_left = int'($urandom_range(lat_max, lat_min)) - 1;
                glog.push_back(m_fetch_pc);
                n_grants++;
            end
            if (do_red)
                m_fetch_pc = rpc;
            else if (accepted)
                m_fetch_pc = m_fetch_pc + 32'd4;
        end
    endtask

    // Scoreboard monitor: compares the queue head whenever decode takes it.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                chk("id_valid", id_valid, 32'(exp_q.size() != 0));
                if (id_valid && id_ready && !redirect && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("id_pc", id_pc, e[63:32]);
                    chk("id_instr", id_instr, e[31:0]);
                    n_pops++;
                end
            end
        end
    end

    initial begin
        int t, g0, p0;
        bit seen;
        rst = 1'b1;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        redirect = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;

        repeat (3) cycle();
        chk("rst_id_valid", id_valid, 32'd0);
        chk("rst_imem_req", imem_req, 32'd0);

        // Back-to-back sequential fetch from reset.
        rst = 1'b0;
        t = 0;
        while (n_grants < 3 && t < 40) begin cycle(); t++; end
        chk("seq_grant_timeout", 32'(n_grants >= 3), 32'd1);
        if (glog.size() >= 3) begin
            chk("seq_addr0", glog[0], 32'h0);
            chk("seq_addr1", glog[1], 32'h4);
            chk("seq_addr2", glog[2], 32'h8);
        end
        t = 0;
        while (n_pops < 3 && t < 20) begin cycle(); t++; end
        chk("seq_pop_timeout", 32'(n_pops >= 3), 32'd1);

        // Back-pressure: queue fills to two and fetching stops.
        ready_pct = 0;
        repeat (20) cycle();
        g0 = n_grants;
        chk("bp_occupancy", n_pushes - n_pops, 32'd2);
        seen = 1'b0;
        repeat (8) begin cycle(); if (imem_req) seen = 1'b1; end
        chk("bp_req_quiet", 32'(seen), 32'd0);
        chk("bp_no_grant", n_grants - g0, 32'd0);
        ready_pct = 100;
        t = 0;
        while (n_grants == g0 && t < 30) begin cycle(); t++; end
        chk("bp_resume", 32'(n_grants > g0), 32'd1);
        repeat (10) cycle();

        // Redirect while waiting for data.
        lat_min = 3; lat_max = 3;
        t = 0;
        while (!(mo == M_LIVE && lat_left > 0) && t < 30) begin cycle(); t++; end
        chk("wait_reach", 32'(mo == M_LIVE && lat_left > 0), 32'd1);
        force_redir = 1'b1; force_pc = 32'h100;
        p0 = n_pushes; g0 = glog.size();
        cycle();
        force_redir = 1'b0;
        t = 0;
        while (n_pushes == p0 && t < 30) begin
            cycle();
            if (n_pushes == p0) chk("wait_redir_id_valid", id_valid, 32'd0);
            t++;
        end
        chk("wait_redir_push_timeout", 32'(n_pushes > p0), 32'd1);
        if (glog.size() > g0) chk("wait_redir_addr", glog[g0], 32'h100);
        repeat (5) cycle();

        // Redirect coincident with grant.
        lat_min = 2; lat_max = 2; gnt_pct = 0;
        t = 0;
        while (!imem_req && t < 30) begin cycle(); t++; end
        chk("req_reach", imem_req, 32'd1);
        gnt_pct = 100; force_redir = 1'b1; force_pc = 32'h200;
        cycle();
        force_redir = 1'b0;
        chk("req_redir_accepted", 32'(mo == M_STALE), 32'd1);
        t = 0;
        while (mo != M_NONE && t < 20) begin cycle(); t++; end
        cycle();
        chk("req_redir_no_push", id_valid, 32'd0);
        repeat (5) cycle();

        // Wrap at the top of the address space.
        lat_min = 1; lat_max = 1;
        force_redir = 1'b1; force_pc = 32'hFFFF_FFFC;
        cycle();
        force_redir = 1'b0;
        g0 = glog.size();
        t = 0;
        while (glog.size() < g0 + 2 && t < 30) begin cycle(); t++; end
        if (glog.size() >= g0 + 2) begin
            chk("wrap_addr", glog[g0], 32'hFFFF_FFFC);
            chk("wrap_next_addr", glog[g0 + 1], 32'h0);
        end else begin
            chk("wrap_timeout", 32'(glog.size()), 32'(g0 + 2));
        end
        repeat (5) cycle();

        // Reset in WAIT with one queued entry, then a stale rvalid.
        ready_pct = 0; lat_min = 3; lat_max = 3;
        t = 0;
        while (!(exp_q.size() == 1 && mo == M_LIVE) && t < 40) begin cycle(); t++; end
        chk("rst_wait_reach", 32'(exp_q.size() == 1 && mo == M_LIVE), 32'd1);
        rst = 1'b1;
        cycle();
        cycle();
        chk("midrst_id_valid", id_valid, 32'd0);
        chk("midrst_imem_req", imem_req, 32'd0);
        chk("midrst_pc_next", pc_next, RESET_PC);
        rst = 1'b0; gnt_pct = 0; stale_rv = 1'b1;
        repeat (2) cycle();
        stale_rv = 1'b0;
        repeat (2) cycle();
        chk("midrst_stale_ignored", id_valid, 32'd0);
        gnt_pct = 100; ready_pct = 100; lat_min = 1; lat_max = 1;
        repeat (10) cycle();

        // Randomised segments.
        for (int seg = 0; seg < 15; seg++) begin
            gnt_pct   = int'($urandom_range(100, 30));
            ready_pct = int'($urandom_range(100, 20));
            lat_min   = 1;
            lat_max   = int'($urandom_range(4, 1));
            redir_pm  = int'($urandom_range(60, 0));
            repeat (200) cycle();
        end
        redir_pm = 0; gnt_pct = 100; ready_pct = 100; lat_max = 1;
        repeat (30) cycle();
        chk("progress", 32'(n_pops > 100), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
